line_clear_engine: RTL and testbench
====================================

Name: line_clear_engine

Overview:
- Multi-cycle row-compaction stage. It sits downstream of the game-control block's lock step ("stick block to board").
- Takes a snapshot of the playfield bitmap and removes every completely filled row. Rows above each removed row are shifted down. Vacated top rows are zero-filled.
- Returns the compacted board and the number of rows removed, so the controller can update the score and run its game-over check on the result.

Parameters:
- BOARD_W, 6, blocks per row.
- BOARD_H, 20, rows per board. Row 0 is the top (spawn/game-over row). Row BOARD_H-1 is the bottom.
- CNT_W, 5, width of lines_cleared. Must satisfy 2^CNT_W > BOARD_H.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled only in IDLE.
- board_in  input  BOARD_W*BOARD_H  board snapshot. Row r is board_in[r*BOARD_W +: BOARD_W]. 1 = occupied.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse when board_out and lines_cleared become valid.
- board_out  output  BOARD_W*BOARD_H  compacted board, same layout as board_in.
- lines_cleared  output  CNT_W  number of full rows removed in the last operation.

Behaviour:
- Reset: async assert forces state=IDLE, busy=0, done=0, board_out=0, lines_cleared=0, and all internal pointers and the working register to 0. This applies mid-operation too: the in-flight job is abandoned and no done pulse is produced.
- FSM states: IDLE, SCAN, FILL, DONE.
- IDLE
  - On start=1: capture board_in into working register wk; rd=BOARD_H-1; wr=BOARD_H-1; cnt=0; go to SCAN.
  - busy rises on the next edge.
  - start while not IDLE is ignored (not queued).
- SCAN: one row per cycle, rd walks from BOARD_H-1 down to 0.
  - If wk row rd is all ones: cnt+=1, wr unchanged.
  - Otherwise: wk row wr <= wk row rd, then wr-=1. This is safe because wr>=rd always, so no unread row is overwritten.
  - After processing rd=0: go to FILL if cnt>0, else go to DONE.
  - SCAN always takes exactly BOARD_H cycles.
- FILL: zero one row per cycle at wr, then wr-=1. Go to DONE after the row-0 write. FILL takes exactly cnt cycles.
- DONE (one cycle): board_out<=wk; lines_cleared<=cnt; done=1; busy=0. Next state is IDLE.
- Latency from the start-accept edge to the done pulse is BOARD_H + cnt + 1 cycles.
- Outputs between operations: board_out and lines_cleared hold their values until the next DONE. They are never updated mid-operation.
- Start on the DONE cycle is ignored. Start on the first IDLE cycle after DONE is accepted, giving a back-to-back throughput of BOARD_H + cnt + 2 cycles.
- Width rules:
  - rd and wr are clog2(BOARD_H) bits. Terminal tests compare against 0 before decrementing; wrap to all-ones is never used.
  - cnt saturates at BOARD_H (unreachable overflow).
- Boundary cases:
  - Empty board: cnt=0, board_out=board_in.
  - All rows full: cnt=BOARD_H, SCAN never writes, FILL zeroes every row, board_out=0.
  - Full row 0: cleared like any other row.
  - Partially filled rows are never altered, only moved.
- board_in is don't-care after the accept edge; the caller may change it freely.

Test Plan:
- Reset then idle: busy=0, done=0, board_out=0, lines_cleared=0. Assert rst mid-SCAN → busy drops immediately, no done pulse follows.
- Empty board, start → done exactly 21 cycles after accept, board_out=0, lines_cleared=0.
- Row 19=6'b111111, row 18=6'b000101, all other rows 0 → done after 22 cycles; board_out row 19=6'b000101, row 18=0, lines_cleared=1.
- Rows 19 and 17 full, row 18=6'b100001, row 16=6'b010010 → board_out row 19=6'b100001, row 18=6'b010010, rows 0..17=0, lines_cleared=2, latency 23 cycles.
- All 20 rows full → board_out=0, lines_cleared=20, latency 41 cycles.
- Pulse start during SCAN with a different board_in → ignored, result reflects the original snapshot. Start on the DONE cycle → ignored. Start the following cycle → accepted, busy=1.

Source files
------------

// File: rtl/line_clear_engine_if.sv
// Request/result bundle for the line clear engine: board snapshot in,
// compacted board and cleared-row count out.
interface line_clear_engine_if #(
    parameter int BOARD_W = 6,
    parameter int BOARD_H = 20,
    parameter int CNT_W   = 5
);
    logic                       start;
    logic [BOARD_W*BOARD_H-1:0] board_in;
    logic                       busy;
    logic                       done;
    logic [BOARD_W*BOARD_H-1:0] board_out;
    logic [CNT_W-1:0]           lines_cleared;

    modport master (
        output start, board_in,
        input  busy, done, board_out, lines_cleared
    );

    modport slave (
        input  start, board_in,
        output busy, done, board_out, lines_cleared
    );
endinterface

// File: rtl/line_clear_engine.sv
// Multi-cycle row compaction: drops every full row of a board snapshot,
// shifts the rows above down and zero-fills the vacated top rows.
module line_clear_engine #(
    parameter int BOARD_W = 6,
    parameter int BOARD_H = 20,
    parameter int CNT_W   = 5
) (
    input logic clk,
    input logic rst,
    line_clear_engine_if.slave bus
);
    localparam int PTR_W = $clog2(BOARD_H);
    localparam int N     = BOARD_W * BOARD_H;
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(BOARD_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOARD_H);

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

    state_t           state, state_nx;
    logic [N-1:0]     wk;
    logic [PTR_W-1:0] rd, wr;
    logic [CNT_W-1:0] cnt;
    logic             row_full;

    assign row_full = &wk[rd*BOARD_W +: BOARD_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = SCAN;
            // The last scanned row may itself be full, so include it in the FILL decision
            SCAN: if (rd == '0) state_nx = (cnt != '0 || row_full) ? FILL : DONE;
            FILL: if (wr == '0) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wk                <= '0;
            rd                <= '0;
            wr                <= '0;
            cnt               <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.board_out     <= '0;
            bus.lines_cleared <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    wk       <= bus.board_in;
                    rd       <= PTR_TOP;
                    wr       <= PTR_TOP;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                end
                SCAN: begin
                    // wr never drops below rd, so the copy cannot clobber an unread row
                    if (row_full) begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    end else begin
                        wk[wr*BOARD_W +: BOARD_W] <= wk[rd*BOARD_W +: BOARD_W];
                        if (wr != '0) wr <= wr - 1'b1;
                    end
                    if (rd != '0) rd <= rd - 1'b1;
                end
                FILL: begin
                    wk[wr*BOARD_W +: BOARD_W] <= '0;
                    if (wr != '0) wr <= wr - 1'b1;
                end
                DONE: begin
                    bus.board_out     <= wk;
                    bus.lines_cleared <= cnt;
                    bus.done          <= 1'b1;
                    bus.busy          <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: hand-built boards with hand-computed
// compacted results, latencies, ignored starts, back-to-back start and reset abort.
module tb_line_clear_engine;
    localparam int W = 6;
    localparam int H = 20;
    localparam int C = 5;
    typedef logic [W*H-1:0] board_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    line_clear_engine_if #(.BOARD_W(W), .BOARD_H(H), .CNT_W(C)) bus ();

    line_clear_engine #(.BOARD_W(W), .BOARD_H(H), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is accepted on the following posedge.
    // poke > 0 re-pulses start with board alt, sampled on posedge poke+1.
    task automatic run_job(input string tag, input board_t b, input board_t eb,
                           input int ec, input int el, input int poke, input board_t alt);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        bus.start    = 1'b1;
        bus.board_in = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.board_in = ~b;
        chk({tag, " busy"}, 128'(bus.busy), 128'(1));
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.start = (lat == poke);
            if (lat == poke) bus.board_in = alt;
            if (bus.done) seen = 1;
        end
        chk({tag, " lat"}, 128'(lat), 128'(el));
        chk({tag, " board"}, 128'(bus.board_out), 128'(eb));
        chk({tag, " cnt"}, 128'(bus.lines_cleared), 128'(ec));
        chk({tag, " busy_end"}, 128'(bus.busy), 128'(0));
    endtask

    initial begin
        board_t b, e, full;
        bit     seen;
        full = '1;
        rst = 1'b1;
        bus.start    = 1'b0;
        bus.board_in = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 128'(bus.busy), 128'(0));
        chk("rst done", 128'(bus.done), 128'(0));
        chk("rst board", 128'(bus.board_out), 128'(0));
        chk("rst cnt", 128'(bus.lines_cleared), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle busy", 128'(bus.busy), 128'(0));

        run_job("empty", '0, '0, 0, 21, 0, '0);
        @(negedge clk);
        chk("pulse once", 128'(bus.done), 128'(0));

        b = '0; b[19*W +: W] = 6'b111111; b[18*W +: W] = 6'b000101;
        e = '0; e[19*W +: W] = 6'b000101;
        run_job("one", b, e, 1, 22, 0, '0);
        @(negedge clk);
        chk("hold cnt", 128'(bus.lines_cleared), 128'(1));
        chk("hold board", 128'(bus.board_out), 128'(e));

        b = '0; b[19*W +: W] = 6'b111111; b[18*W +: W] = 6'b100001;
        b[17*W +: W] = 6'b111111; b[16*W +: W] = 6'b010010;
        e = '0; e[19*W +: W] = 6'b100001; e[18*W +: W] = 6'b010010;
        run_job("two", b, e, 2, 23, 0, '0);
        @(negedge clk);

        b = '0; b[0] = 1'b0; b[0*W +: W] = 6'b111111;
        b[19*W +: W] = 6'b101010; b[5*W +: W] = 6'b010001;
        e = '0; e[19*W +: W] = 6'b101010; e[5*W +: W] = 6'b010001;
        run_job("row0", b, e, 1, 22, 0, '0);
        @(negedge clk);

        run_job("all", full, '0, 20, 41, 0, '0);
        @(negedge clk);

        // start during SCAN with a different board is ignored
        b = '0; b[19*W +: W] = 6'b111111; b[18*W +: W] = 6'b000101;
        e = '0; e[19*W +: W] = 6'b000101;
        run_job("scan_poke", b, e, 1, 22, 5, full);
        @(negedge clk);

        // start on the DONE cycle is ignored; start right after is accepted
        b = '0; b[19*W +: W] = 6'b111111; b[18*W +: W] = 6'b100001;
        b[17*W +: W] = 6'b111111; b[16*W +: W] = 6'b010010;
        e = '0; e[19*W +: W] = 6'b100001; e[18*W +: W] = 6'b010010;
        run_job("done_poke", b, e, 2, 23, 22, full);
        run_job("b2b", full, '0, 20, 41, 0, '0);
        @(negedge clk);
        chk("b2b idle", 128'(bus.busy), 128'(0));

        // reset mid-SCAN abandons the job
        b = '0; b[19*W +: W] = 6'b111111;
        bus.start    = 1'b1;
        bus.board_in = b;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid busy pre", 128'(bus.busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid busy", 128'(bus.busy), 128'(0));
        chk("mid board", 128'(bus.board_out), 128'(0));
        chk("mid cnt", 128'(bus.lines_cleared), 128'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        chk("no done after rst", 128'(seen), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
